clk_div_ratio_ctrl: RTL and testbench

Run-time configuration controller for the programmable clock divider (i_ref_clk domain, 8-bit ratio, clock-enable input). Accepts ratio-change requests over a valid/ready handshake, range-checks them and applies them glitch-free: it gates the divider at a low phase of the divided clock, loads the new ratio, re-enables the divider and waits a settle window before signalling completion. It sits between the register/config interface and the divider instance.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_edge_det.sv | 31 +++
 rtl/clk_div_ratio_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_clk_div_ratio_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the divider ratio controller
// Purpose: state encoding, ratio width/limits and the legal-ratio check used by
//          clk_div_ratio_ctrl.
// Ports:   none (package).
package clk_div_pkg;

  localparam int                 RATIO_W   = 8;
  localparam logic [RATIO_W-1:0] MIN_RATIO = 8'd2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT_EDGE,
    GATE,
    LOAD,
    SETTLE
  } state_e;

  function automatic logic ratio_legal(input logic [RATIO_W-1:0] ratio,
                                       input logic [RATIO_W-1:0] max_ratio);
    return (ratio >= MIN_RATIO) && (ratio <= max_ratio);
  endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// rtl/clk_div_edge_det.sv - falling-edge detector for the fed-back divided clock
// Purpose: registers one sample of the divided clock and flags a 1 -> 0 step.
// Ports:
//   i_clk    in   reference clock
//   i_rst_n  in   asynchronous active-low reset
//   i_sig    in   divided clock, same domain, sampled directly
//   i_clear  in   forget edge history (sample register forced to 0)
//   o_fall   out  combinational: previous sample 1, current value 0
module clk_div_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  input  logic i_clear,
  output logic o_fall
);

  logic sig_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sig_q <= 1'b0;
    end else if (i_clear) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= i_sig;
    end
  end

  assign o_fall = sig_q & ~i_sig;

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// rtl/clk_div_ratio_ctrl.sv - glitch-free run-time ratio controller for the clock divider
// Purpose: accepts ratio requests, range-checks them, gates the divider at a low
//          phase of its output, loads the new ratio, re-enables and waits a
//          settle window before reporting completion.
// Ports:
//   i_ref_clk    in   reference clock (only clock)
//   i_rst_n      in   asynchronous active-low reset
//   i_req_valid  in   ratio change request
//   i_req_ratio  in   requested ratio, taken on valid && ready
//   o_req_ready  out  high only in IDLE
//   i_div_clk    in   divider output fed back
//   o_clk_en     out  divider clock enable
//   o_div_ratio  out  divider ratio
//   o_busy       out  high whenever not IDLE
//   o_done       out  1-cycle pulse, request applied
//   o_err        out  1-cycle pulse, request rejected or edge timeout
//   o_timeout    out  sticky edge-timeout flag, cleared by a legal request
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter logic [RATIO_W-1:0] DEFAULT_RATIO  = 8'd2,
  parameter logic [RATIO_W-1:0] MAX_RATIO      = 8'd255,
  parameter int                 GATE_CYC       = 2,
  parameter int                 SETTLE_PERIODS = 2
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  output logic               o_req_ready,
  input  logic               i_div_clk,
  output logic               o_clk_en,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_timeout
);

  localparam logic [3:0] GATE_LAST = 4'(GATE_CYC - 1);
  localparam logic [9:0] SETTLE_MUL = 10'(SETTLE_PERIODS);

  state_e             state_q, state_d;
  logic               clk_en_q, clk_en_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] new_ratio_q, new_ratio_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               timeout_q, timeout_d;
  logic [9:0]         tmo_cnt_q, tmo_cnt_d;
  logic [3:0]         gate_cnt_q, gate_cnt_d;
  logic [9:0]         settle_cnt_q, settle_cnt_d;

  logic               edge_clear;
  logic               div_fall;
  logic [9:0]         tmo_last;
  logic [9:0]         settle_last;

  // Edge window is 2*ratio+2 cycles, so the last count is 2*ratio+1.
  assign tmo_last    = {1'b0, ratio_q, 1'b1};
  assign settle_last = SETTLE_MUL * {2'b00, new_ratio_q} - 10'd1;

  clk_div_edge_det u_edge_det (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_div_clk),
    .i_clear (edge_clear),
    .o_fall  (div_fall)
  );

  always_comb begin
    state_d      = state_q;
    clk_en_d     = clk_en_q;
    ratio_d      = ratio_q;
    new_ratio_d  = new_ratio_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    timeout_d    = timeout_q;
    tmo_cnt_d    = tmo_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    settle_cnt_d = settle_cnt_q;
    edge_clear   = 1'b0;

    case (state_q)
      INIT: begin
        clk_en_d = 1'b1;
        state_d  = IDLE;
      end

      IDLE: begin
        if (i_req_valid) begin
          if (!ratio_legal(i_req_ratio, MAX_RATIO)) begin
            err_d = 1'b1;
          end else begin
            timeout_d = 1'b0;
            if (i_req_ratio == ratio_q) begin
              done_d = 1'b1;
            end else begin
              new_ratio_d = i_req_ratio;
              tmo_cnt_d   = 10'd0;
              // Stale samples from before the request must not count as an edge.
              edge_clear  = 1'b1;
              state_d     = WAIT_EDGE;
            end
          end
        end
      end

      WAIT_EDGE: begin
        if (div_fall) begin
          clk_en_d   = 1'b0;
          gate_cnt_d = 4'd0;
          state_d    = GATE;
        end else if (tmo_cnt_q == tmo_last) begin
          // No edge seen (divider stuck): flag it but still apply the change.
          timeout_d  = 1'b1;
          err_d      = 1'b1;
          clk_en_d   = 1'b0;
          gate_cnt_d = 4'd0;
          state_d    = GATE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
      end

      GATE: begin
        clk_en_d = 1'b0;
        if (gate_cnt_q == GATE_LAST) begin
          ratio_d = new_ratio_q;
          state_d = LOAD;
        end else begin
          gate_cnt_d = gate_cnt_q + 4'd1;
        end
      end

      LOAD: begin
        clk_en_d     = 1'b1;
        settle_cnt_d = 10'd0;
        state_d      = SETTLE;
      end

      SETTLE: begin
        if (settle_cnt_q == settle_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 10'd1;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= INIT;
      clk_en_q     <= 1'b0;
      ratio_q      <= DEFAULT_RATIO;
      new_ratio_q  <= DEFAULT_RATIO;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      tmo_cnt_q    <= 10'd0;
      gate_cnt_q   <= 4'd0;
      settle_cnt_q <= 10'd0;
    end else begin
      state_q      <= state_d;
      clk_en_q     <= clk_en_d;
      ratio_q      <= ratio_d;
      new_ratio_q  <= new_ratio_d;
      done_q       <= done_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = ratio_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// tb/tb_clk_div_ratio_ctrl.sv - directed self-checking bench for clk_div_ratio_ctrl
module tb_clk_div_ratio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_ratio = 8'd0;
  logic       tie_low = 1'b0;

  logic       o_req_ready;
  logic       o_clk_en;
  logic [7:0] o_div_ratio;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic       o_timeout;
  logic       i_div_clk;

  logic [7:0] dcnt;
  logic       div_model;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Simple divider: counts while enabled, output high for the first ratio/2 counts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= 8'd0;
    else if (o_clk_en) dcnt <= (dcnt >= o_div_ratio - 8'd1) ? 8'd0 : dcnt + 8'd1;
  end
  assign div_model = (dcnt < (o_div_ratio >> 1));
  assign i_div_clk = tie_low ? 1'b0 : div_model;

  clk_div_ratio_ctrl #(
    .DEFAULT_RATIO  (8'd2),
    .MAX_RATIO      (8'd200),
    .GATE_CYC       (2),
    .SETTLE_PERIODS (2)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (o_req_ready),
    .i_div_clk   (i_div_clk),
    .o_clk_en    (o_clk_en),
    .o_div_ratio (o_div_ratio),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_timeout   (o_timeout)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send(input logic [7:0] r);
    int n;
    n = 0;
    while (!o_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", int'(o_req_ready), 1);
    req_valid = 1'b1;
    req_ratio = r;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic measure_period(output int p);
    int   first;
    logic prev;
    first = -1;
    p     = -1;
    prev  = i_div_clk;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!prev && i_div_clk) begin
        if (first < 0) first = c;
        else begin
          p = c - first;
          break;
        end
      end
      prev = i_div_clk;
    end
  endtask

  // Watches one change from the negedge after the handshake until o_done.
  task automatic observe(input int budget, output int t_done, output int t_err,
                         output int n_err, output int n_en_low, output int t_rise,
                         output int ratio_low, output int fall_ok);
    int   first_low;
    logic p1, p2;
    t_done = -1; t_err = -1; n_err = 0; n_en_low = 0; t_rise = -1;
    ratio_low = -1; fall_ok = 0; first_low = -1; p1 = 1'b0; p2 = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (o_err) begin
        n_err++;
        if (t_err < 0) t_err = c;
      end
      if (!o_clk_en) begin
        n_en_low++;
        ratio_low = int'(o_div_ratio);
        if (first_low < 0) begin
          first_low = c;
          fall_ok = (c >= 2 && p1 == 1'b0 && p2 == 1'b1) ? 1 : 0;
        end
      end else if (first_low >= 0 && t_rise < 0) begin
        t_rise = c;
      end
      if (o_done) begin
        t_done = c;
        break;
      end
      p2 = p1;
      p1 = i_div_clk;
      @(negedge clk);
    end
  endtask

  initial begin
    int         p, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok, found;
    logic [7:0] bad [3];
    bad[0] = 8'd0;
    bad[1] = 8'd1;
    bad[2] = 8'd255;

    // 1: reset values, start-up, period at default ratio
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_clk_en", int'(o_clk_en), 0);
    chk("rst_ratio", int'(o_div_ratio), 2);
    chk("rst_ready", int'(o_req_ready), 0);
    chk("rst_busy", int'(o_busy), 1);
    chk("rst_done", int'(o_done), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_clk_en", int'(o_clk_en), 1);
    chk("t1_ready", int'(o_req_ready), 1);
    chk("t1_busy", int'(o_busy), 0);
    chk("t1_done", int'(o_done), 0);
    measure_period(p);
    chk("t1_period", p, 2);

    // 2: 2 -> 5
    send(8'd5);
    chk("t2_busy", int'(o_busy), 1);
    chk("t2_ready", int'(o_req_ready), 0);
    observe(100, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok);
    chk("t2_done_seen", (t_done >= 0) ? 1 : 0, 1);
    chk("t2_no_err", n_err, 0);
    chk("t2_en_low_cycles", n_low, 3);
    chk("t2_ratio_while_low", r_low, 5);
    chk("t2_after_fall", f_ok, 1);
    chk("t2_rise_to_done", t_done - t_rise, 10);
    chk("t2_ratio", int'(o_div_ratio), 5);
    measure_period(p);
    chk("t2_period", p, 5);

    // 3: illegal requests with MAX_RATIO=200
    for (int i = 0; i < 3; i++) begin
      send(bad[i]);
      chk("t3_err", int'(o_err), 1);
      chk("t3_done", int'(o_done), 0);
      chk("t3_ratio", int'(o_div_ratio), 5);
      chk("t3_clk_en", int'(o_clk_en), 1);
      chk("t3_busy", int'(o_busy), 0);
      @(negedge clk);
      chk("t3_err_pulse", int'(o_err), 0);
    end

    // 4: 5 -> 3, then 3 -> 3
    send(8'd3);
    observe(100, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok);
    chk("t4_change_done", (t_done >= 0) ? 1 : 0, 1);
    chk("t4_ratio", int'(o_div_ratio), 3);
    send(8'd3);
    chk("t4_same_done", int'(o_done), 1);
    chk("t4_same_clk_en", int'(o_clk_en), 1);
    chk("t4_same_busy", int'(o_busy), 0);
    chk("t4_same_ratio", int'(o_div_ratio), 3);
    @(negedge clk);
    chk("t4_done_pulse", int'(o_done), 0);
    chk("t4_clk_en_after", int'(o_clk_en), 1);

    // 5: edge timeout at ratio 4, request 6
    send(8'd4);
    observe(100, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok);
    chk("t5_to4_ratio", int'(o_div_ratio), 4);
    tie_low = 1'b1;
    send(8'd6);
    observe(100, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok);
    chk("t5_err_time", t_err, 10);
    chk("t5_err_count", n_err, 1);
    chk("t5_done_seen", (t_done >= 0) ? 1 : 0, 1);
    chk("t5_timeout", int'(o_timeout), 1);
    chk("t5_ratio", int'(o_div_ratio), 6);
    chk("t5_rise_to_done", t_done - t_rise, 12);
    tie_low = 1'b0;
    send(8'd2);
    chk("t5_timeout_clr", int'(o_timeout), 0);
    observe(100, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok);
    chk("t5_back_ratio", int'(o_div_ratio), 2);

    // 6: reset during SETTLE of 2 -> 6
    send(8'd6);
    found = 0;
    n_low = 0;
    for (int c = 0; c < 200; c++) begin
      if (!o_clk_en) n_low = 1;
      if (n_low == 1 && o_clk_en && o_busy) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_reach_settle", found, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_clk_en", int'(o_clk_en), 0);
    chk("t6_rst_ratio", int'(o_div_ratio), 2);
    chk("t6_rst_ready", int'(o_req_ready), 0);
    chk("t6_rst_busy", int'(o_busy), 1);
    chk("t6_rst_done", int'(o_done), 0);
    chk("t6_rst_err", int'(o_err), 0);
    chk("t6_rst_timeout", int'(o_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_clk_en", int'(o_clk_en), 1);
    chk("t6_ready", int'(o_req_ready), 1);
    measure_period(p);
    chk("t6_period", p, 2);
    send(8'd3);
    observe(100, t_done, t_err, n_err, n_low, t_rise, r_low, f_ok);
    chk("t6_resume_done", (t_done >= 0) ? 1 : 0, 1);
    chk("t6_resume_ratio", int'(o_div_ratio), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
